// File: rtl/pb_event_decoder.sv
// Push-button event decoder: turns a debounced button level into one-cycle
// press / release / click / long-press / repeat pulses timed by an internal tick.
module pb_event_decoder #(
   parameter int unsigned TICK_DIV     = 24000,
   parameter int unsigned LONG_TICKS   = 800,
   parameter int unsigned DCLICK_TICKS = 300,
   parameter int unsigned REPEAT_TICKS = 150,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clean_pb_i,
   output logic held_o,
   output logic press_o,
   output logic release_o,
   output logic short_click_o,
   output logic double_click_o,
   output logic long_press_o,
   output logic repeat_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS,
      S_HOLD,
      S_WAIT2,
      S_DBL
   } state_e;

   localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);
   localparam logic [15:0] LONG_T   = 16'(LONG_TICKS);
   localparam logic [15:0] DCLICK_T = 16'(DCLICK_TICKS);
   localparam logic [15:0] REPEAT_T = 16'(REPEAT_TICKS);
   localparam logic [15:0] T_MAX    = 16'hFFFF;

   logic        p_q, p_prev_q, rise_q, fall_q;
   logic [15:0] pre_q, pre_d;
   logic [15:0] t_q, t_d, t_inc;
   logic        tick, clr, rep_clr;
   logic        hit_long, hit_dclick, hit_repeat;
   state_e      state_q, state_d;

   logic press_d, release_d, short_d, double_d, long_d, repeat_d;
   logic press_q, release_q, short_q, double_q, long_q, repeat_q;

   // Input register, delayed copy and registered edge flags: the edge flags
   // add the stage that places press/release three cycles after the input.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q      <= 1'b0;
         p_prev_q <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
      end else begin
         p_q      <= clean_pb_i ^ ACTIVE_LOW;
         p_prev_q <= p_q;
         rise_q   <= p_q & ~p_prev_q;
         fall_q   <= ~p_q & p_prev_q;
      end
   end

   assign tick  = (pre_q == DIV_LAST);
   assign t_inc = (t_q == T_MAX) ? t_q : t_q + 16'd1;

   // Thresholds are judged on the value t takes after this tick.
   assign hit_long   = tick && (t_inc == LONG_T);
   assign hit_dclick = tick && (t_inc == DCLICK_T);
   assign hit_repeat = tick && (t_inc == REPEAT_T);

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      short_d   = 1'b0;
      double_d  = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      rep_clr   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rise_q) begin
               press_d = 1'b1;
               state_d = S_PRESS;
            end
         end

         S_PRESS: begin
            if (fall_q) begin
               release_d = 1'b1;
               if (DCLICK_T == 16'd0) begin
                  short_d = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT2;
               end
            end else if (hit_long) begin
               long_d  = 1'b1;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (fall_q) begin
               release_d = 1'b1;
               state_d   = S_IDLE;
            end else if ((REPEAT_T != 16'd0) && hit_repeat) begin
               repeat_d = 1'b1;
               rep_clr  = 1'b1;
            end
         end

         S_WAIT2: begin
            if (rise_q) begin
               press_d  = 1'b1;
               double_d = 1'b1;
               state_d  = S_DBL;
            end else if (hit_dclick) begin
               short_d = 1'b1;
               state_d = S_IDLE;
            end
         end

         S_DBL: begin
            if (fall_q) begin
               release_d = 1'b1;
               state_d   = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Prescaler and tick counter restart together whenever timing must restart.
   always_comb begin
      clr   = (state_d != state_q) || rise_q || fall_q || rep_clr;
      pre_d = pre_q + 16'd1;
      t_d   = t_q;
      if (clr) begin
         pre_d = '0;
         t_d   = '0;
      end else if (tick) begin
         pre_d = '0;
         t_d   = t_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pre_q     <= '0;
         t_q       <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         short_q   <= 1'b0;
         double_q  <= 1'b0;
         long_q    <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         t_q       <= t_d;
         press_q   <= press_d;
         release_q <= release_d;
         short_q   <= short_d;
         double_q  <= double_d;
         long_q    <= long_d;
         repeat_q  <= repeat_d;
      end
   end

   assign held_o         = p_prev_q;
   assign press_o        = press_q;
   assign release_o      = release_q;
   assign short_click_o  = short_q;
   assign double_click_o = double_q;
   assign long_press_o   = long_q;
   assign repeat_o       = repeat_q;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Bench for pb_event_decoder: directed scenarios plus random press/release
// runs, checked every cycle against an elapsed-time reference model.
module tb_pb_event_decoder;

   localparam int DIV  = 4;
   localparam int LONG = 10;
   localparam int DCL  = 5;
   localparam int REP  = 3;

   // pulse indices into the 6-bit pulse vector
   localparam int P_PRESS = 0;
   localparam int P_REL   = 1;
   localparam int P_SHORT = 2;
   localparam int P_DBL   = 3;
   localparam int P_LONG  = 4;
   localparam int P_REP   = 5;

   localparam int M_IDLE  = 0;
   localparam int M_PRESS = 1;
   localparam int M_HOLD  = 2;
   localparam int M_WAIT2 = 3;
   localparam int M_DBL   = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic clean_pb;
   logic held_w, press_w, rel_w, short_w, dbl_w, long_w, rep_w;

   int    vectors     = 0;
   int    miscompares = 0;
   int    cyc         = 0;
   string cur_test    = "init";

   logic       h1, h2, h3;
   int         m_st, m_clr;
   logic       exp_held;
   logic [5:0] exp_pulse;

   int n_p[6];
   int f_p[6];
   int l_p[6];
   int rep_at[3];
   int s_mark, r_mark;

   pb_event_decoder #(
      .TICK_DIV     (DIV),
      .LONG_TICKS   (LONG),
      .DCLICK_TICKS (DCL),
      .REPEAT_TICKS (REP),
      .ACTIVE_LOW   (1'b1)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .clean_pb_i     (clean_pb),
      .held_o         (held_w),
      .press_o        (press_w),
      .release_o      (rel_w),
      .short_click_o  (short_w),
      .double_click_o (dbl_w),
      .long_press_o   (long_w),
      .repeat_o       (rep_w)
   );

   always #5 clk = ~clk;

   task automatic clear_log();
      for (int i = 0; i < 6; i++) begin
         n_p[i] = 0;
         f_p[i] = -1;
         l_p[i] = -1;
      end
      for (int i = 0; i < 3; i++) rep_at[i] = -1;
   endtask

   // Reference model for edge number cyc. The level driven before edge k is
   // seen as an edge by the decision made at edge k+2; thresholds are judged
   // as elapsed clock cycles since the last restart, ticks times DIV.
   task automatic model_edge(input logic lvl);
      logic rise, fall;
      int   el;
      rise      = h2 & ~h3;
      fall      = ~h2 & h3;
      el        = cyc - m_clr;
      exp_pulse = '0;
      exp_held  = h1;
      case (m_st)
         M_IDLE: if (rise) begin
            exp_pulse[P_PRESS] = 1'b1;
            m_st = M_PRESS; m_clr = cyc;
         end
         M_PRESS: if (fall) begin
            exp_pulse[P_REL] = 1'b1;
            if (DCL == 0) begin
               exp_pulse[P_SHORT] = 1'b1;
               m_st = M_IDLE;
            end else begin
               m_st = M_WAIT2;
            end
            m_clr = cyc;
         end else if (el == LONG * DIV) begin
            exp_pulse[P_LONG] = 1'b1;
            m_st = M_HOLD; m_clr = cyc;
         end
         M_HOLD: if (fall) begin
            exp_pulse[P_REL] = 1'b1;
            m_st = M_IDLE; m_clr = cyc;
         end else if (REP != 0 && el == REP * DIV) begin
            exp_pulse[P_REP] = 1'b1;
            m_clr = cyc;
         end
         M_WAIT2: if (rise) begin
            exp_pulse[P_PRESS] = 1'b1;
            exp_pulse[P_DBL]   = 1'b1;
            m_st = M_DBL; m_clr = cyc;
         end else if (el == DCL * DIV) begin
            exp_pulse[P_SHORT] = 1'b1;
            m_st = M_IDLE; m_clr = cyc;
         end
         default: if (fall) begin
            exp_pulse[P_REL] = 1'b1;
            m_st = M_IDLE; m_clr = cyc;
         end
      endcase
      h3 = h2;
      h2 = h1;
      h1 = lvl;
   endtask

   task automatic check_vec(input string tag);
      logic [6:0] obs, expv;
      obs  = {held_w, rep_w, long_w, dbl_w, short_w, rel_w, press_w};
      expv = {exp_held, exp_pulse};
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, expv);
      end
      for (int i = 0; i < 6; i++) begin
         if (obs[i] === 1'b1) begin
            if (i == P_REP && n_p[i] < 3) rep_at[n_p[i]] = cyc;
            n_p[i]++;
            if (f_p[i] < 0) f_p[i] = cyc;
            l_p[i] = cyc;
         end
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // lvl = 1 means pressed; the button is active-low on the pin.
   task automatic step(input logic lvl);
      clean_pb = ~lvl;
      @(posedge clk);
      cyc++;
      model_edge(lvl);
      #1;
      check_vec(cur_test);
      @(negedge clk);
   endtask

   task automatic hold_for(input logic lvl, input int n);
      for (int i = 0; i < n; i++) step(lvl);
   endtask

   task automatic do_reset(input int n, input logic lvl);
      clean_pb  = ~lvl;
      rst_n     = 1'b0;
      #1;
      exp_held  = 1'b0;
      exp_pulse = '0;
      check_vec("reset");
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         cyc++;
         #1;
         check_vec("reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
      m_st  = M_IDLE;
      m_clr = cyc;
   endtask

   initial begin
      clear_log();
      do_reset(3, 1'b0);
      cur_test = "idle";
      hold_for(1'b0, 5);

      // Short click: press and release three cycles after the pin edges.
      cur_test = "short_click";
      clear_log();
      s_mark = cyc + 1;
      hold_for(1'b1, 20);
      r_mark = cyc + 1;
      hold_for(1'b0, 30);
      check_int("sc_press_lat", f_p[P_PRESS] - s_mark + 1, 3);
      check_int("sc_rel_lat", f_p[P_REL] - r_mark + 1, 3);
      check_int("sc_short_gap", f_p[P_SHORT] - f_p[P_REL], 20);
      check_int("sc_n_short", n_p[P_SHORT], 1);
      check_int("sc_n_other", n_p[P_DBL] + n_p[P_LONG] + n_p[P_REP], 0);

      // Double click.
      cur_test = "double_click";
      clear_log();
      hold_for(1'b1, 12);
      hold_for(1'b0, 8);
      hold_for(1'b1, 12);
      hold_for(1'b0, 30);
      check_int("dc_n_press", n_p[P_PRESS], 2);
      check_int("dc_n_rel", n_p[P_REL], 2);
      check_int("dc_n_dbl", n_p[P_DBL], 1);
      check_int("dc_dbl_with_press", f_p[P_DBL], l_p[P_PRESS]);
      check_int("dc_n_short_long", n_p[P_SHORT] + n_p[P_LONG], 0);

      // Long press with repeat; the release lands on a repeat threshold.
      cur_test = "long_repeat";
      clear_log();
      hold_for(1'b1, 100);
      hold_for(1'b0, 30);
      check_int("lp_long_delay", f_p[P_LONG] - f_p[P_PRESS], 40);
      check_int("lp_rep1", rep_at[0] - f_p[P_LONG], 12);
      check_int("lp_rep2", rep_at[1] - f_p[P_LONG], 24);
      check_int("lp_rep3", rep_at[2] - f_p[P_LONG], 36);
      check_int("lp_n_rep", n_p[P_REP], 4);
      check_int("lp_n_rel", n_p[P_REL], 1);
      check_int("lp_n_short", n_p[P_SHORT], 0);

      // Gap expiry: second press arrives one cycle after the gap closes.
      cur_test = "gap_expiry";
      clear_log();
      hold_for(1'b1, 10);
      hold_for(1'b0, 21);
      hold_for(1'b1, 10);
      hold_for(1'b0, 30);
      check_int("ge_n_dbl", n_p[P_DBL], 0);
      check_int("ge_short_gap", f_p[P_SHORT] - f_p[P_REL], 20);
      check_int("ge_press_after", int'(l_p[P_PRESS] > f_p[P_SHORT]), 1);
      check_int("ge_n_press", n_p[P_PRESS], 2);

      // Second press lands on the very edge the gap closes: edge wins.
      cur_test = "gap_boundary";
      clear_log();
      hold_for(1'b1, 10);
      hold_for(1'b0, 20);
      hold_for(1'b1, 10);
      hold_for(1'b0, 30);
      check_int("gb_n_dbl", n_p[P_DBL], 1);
      check_int("gb_n_short", n_p[P_SHORT], 0);

      // Reset in the middle of a hold with the button kept down.
      cur_test = "reset_mid";
      hold_for(1'b1, 25);
      do_reset(3, 1'b1);
      cur_test = "after_reset";
      clear_log();
      r_mark = cyc + 1;
      hold_for(1'b1, 60);
      hold_for(1'b0, 30);
      check_int("rs_press_lat", f_p[P_PRESS] - r_mark + 1, 3);
      check_int("rs_long_delay", f_p[P_LONG] - f_p[P_PRESS], 40);

      // Release on the same edge the long threshold is reached.
      cur_test = "collision";
      clear_log();
      hold_for(1'b1, 40);
      hold_for(1'b0, 30);
      check_int("co_n_long", n_p[P_LONG], 0);
      check_int("co_rel_delay", f_p[P_REL] - f_p[P_PRESS], 40);
      check_int("co_short_gap", f_p[P_SHORT] - f_p[P_REL], 20);

      // Random press/release durations against the model.
      cur_test = "random";
      clear_log();
      for (int k = 0; k < 40; k++) begin
         logic lv;
         lv = (k % 2 == 0);
         hold_for(lv, int'($urandom_range(60, 1)));
      end
      hold_for(1'b0, 40);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
